spi_mem_device: RTL and testbench



---
 rtl/spi_dev_pkg.sv | 21 ++
 rtl/spi_edge_sync.sv | 49 ++++
 rtl/spi_mem_device.sv | 146 ++++++++++++++
 tb/tb_spi_mem_device.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_dev_pkg.sv
// Shared types and frame constants for the SPI register-memory device.
// Imported by spi_edge_sync and spi_mem_device.
package spi_dev_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_RDATA,
        ST_DONE
    } state_t;

    localparam int CMD_W      = 8;
    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 16;
    localparam int CMD_WR_BIT = 7;

    // Wide enough to count all 16 frame rises without wrapping.
    localparam int CNT_W = $clog2(FRAME_BITS + 1);

endpackage

// File: rtl/spi_edge_sync.sv
// Pin synchronizer for sclk/cs/mosi plus sclk edge detection.
// Ports: clk, rst, sclk/cs/mosi pins in; sclk_rise, sclk_fall, cs_n_sync, mosi_sync out.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic cs,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_n_sync,
    output logic mosi_sync
);
    import spi_dev_pkg::*;

    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] cs_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   sclk_d;

    // cs resets to "low" so a device leaving reset with cs held low
    // never sees a falling edge and cannot start a bogus frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= '0;
            cs_q   <= '0;
            mosi_q <= '0;
            sclk_d <= 1'b0;
        end else begin
            sclk_q[0] <= sclk;
            cs_q[0]   <= cs;
            mosi_q[0] <= mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sclk_q[i] <= sclk_q[i-1];
                cs_q[i]   <= cs_q[i-1];
                mosi_q[i] <= mosi_q[i-1];
            end
            sclk_d <= sclk_q[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_d;
    assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_d;
    assign cs_n_sync = cs_q[SYNC_STAGES-1];
    assign mosi_sync = mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_mem_device.sv
// SPI-slave 8-bit register memory: 16-bit frames of command then data.
// Ports: clk, rst, SPI pins (sclk, cs, mosi, miso), busy, wr/rd strobes, debug read port.
module spi_mem_device
    import spi_dev_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    output logic              busy,
    output logic              wr_pulse,
    output logic              rd_pulse,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [7:0]        dbg_data
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic sclk_rise, sclk_fall, cs_n_sync, mosi_sync;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs        (cs),
        .mosi      (mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_n_sync (cs_n_sync),
        .mosi_sync (mosi_sync)
    );

    state_t             state, state_next;
    logic               cs_n_d;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-2:0]  shreg;
    logic [DATA_W-1:0]  sh_in;
    logic [DATA_W-1:0]  oshreg;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic do_shift, do_count, do_write, do_rd_load, do_miso_out;

    // Byte as it will look once the bit arriving this cycle is included.
    assign sh_in = {shreg, mosi_sync};

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next  = state;
        do_shift    = 1'b0;
        do_count    = 1'b0;
        do_write    = 1'b0;
        do_rd_load  = 1'b0;
        do_miso_out = 1'b0;
        if (cs_n_sync) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                // A low cs without a seen falling edge (reset with cs
                // held low) parks in DONE until cs cycles.
                ST_IDLE: state_next = cs_n_d ? ST_CMD : ST_DONE;
                ST_CMD: begin
                    if (sclk_rise) begin
                        do_shift = 1'b1;
                        if (cnt == CNT_W'(CMD_W - 1)) begin
                            if (sh_in[CMD_WR_BIT]) begin
                                state_next = ST_WDATA;
                            end else begin
                                state_next = ST_RDATA;
                                do_rd_load = 1'b1;
                            end
                        end
                    end
                end
                ST_WDATA: begin
                    if (sclk_rise) begin
                        do_shift = 1'b1;
                        if (cnt == CNT_W'(FRAME_BITS - 1)) begin
                            do_write   = 1'b1;
                            state_next = ST_DONE;
                        end
                    end
                end
                ST_RDATA: begin
                    if (sclk_rise) begin
                        do_count = 1'b1;
                    end else if (sclk_fall) begin
                        if (cnt == CNT_W'(FRAME_BITS)) state_next = ST_DONE;
                        else                           do_miso_out = 1'b1;
                    end
                end
                ST_DONE: state_next = ST_DONE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_n_d   <= 1'b0;
            cnt      <= '0;
            shreg    <= '0;
            oshreg   <= '0;
            addr     <= '0;
            miso     <= 1'b0;
            busy     <= 1'b0;
            wr_pulse <= 1'b0;
            rd_pulse <= 1'b0;
            dbg_data <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            cs_n_d   <= cs_n_sync;
            busy     <= (state_next != ST_IDLE);
            wr_pulse <= do_write;
            rd_pulse <= do_rd_load;
            // Reads the pre-write value when both hit one address.
            dbg_data <= mem[dbg_addr];

            if (state == ST_IDLE)         cnt <= '0;
            else if (do_shift | do_count) cnt <= cnt + CNT_W'(1);

            if (do_shift) shreg <= sh_in[DATA_W-2:0];

            if (do_rd_load | (do_shift & (state == ST_CMD)))
                addr <= sh_in[ADDR_W-1:0];
            if (do_rd_load) oshreg <= mem[sh_in[ADDR_W-1:0]];
            if (do_write)   mem[addr] <= sh_in;

            if (do_miso_out) begin
                miso   <= oshreg[DATA_W-1];
                oshreg <= {oshreg[DATA_W-2:0], 1'b0};
            end else if (state_next != ST_RDATA) begin
                miso <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_mem_device.sv
// Scoreboard bench for spi_mem_device: directed frames then random traffic.
// Stimulus pushes expected write/read events; a monitor pops and compares.
module tb_spi_mem_device;

    localparam int ADDR_W = 4;
    localparam int SYNC   = 2;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sclk = 1'b0;
    logic              cs = 1'b1;
    logic              mosi = 1'b0;
    logic              miso, busy, wr_pulse, rd_pulse;
    logic [ADDR_W-1:0] dbg_addr = '0;
    logic [7:0]        dbg_data;

    spi_mem_device #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC)) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .cs       (cs),
        .mosi     (mosi),
        .miso     (miso),
        .busy     (busy),
        .wr_pulse (wr_pulse),
        .rd_pulse (rd_pulse),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] model [DEPTH];
    int         exp_wr [$];
    logic [7:0] exp_rd [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Monitor: strobes and the serial read-back, sampled 1 after posedge.
    initial begin : monitor
        logic       rd_active = 1'b0;
        logic       post_chk = 1'b0;
        logic [7:0] got = '0;
        logic [7:0] want = '0;
        int         nb = 0;
        logic       sclk_p = 1'b0;
        logic       cs_p = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (wr_pulse) begin
                if (exp_wr.size() == 0) check("unexpected_wr_pulse", 1, 0);
                else check("wr_pulse", exp_wr.pop_front(), 1);
            end
            if (rd_pulse) begin
                if (exp_rd.size() == 0) begin
                    check("unexpected_rd_pulse", 1, 0);
                end else begin
                    want = exp_rd.pop_front();
                    rd_active = 1'b1;
                    nb = 0;
                end
            end else if (rd_active && sclk && !sclk_p) begin
                got = {got[6:0], miso};
                nb++;
                if (nb == 8) begin
                    check("read_data", got, want);
                    rd_active = 1'b0;
                    post_chk = 1'b1;
                end
            end
            if (post_chk && cs && !cs_p) begin
                check("miso_after_read", miso, 0);
                post_chk = 1'b0;
            end
            sclk_p = sclk;
            cs_p = cs;
        end
    end

    task automatic spi_frame(input logic [23:0] bits, input int nbits,
                             input int half, input int gap, input bit chk_busy);
        int n;
        @(negedge clk);
        cs = 1'b0;
        repeat (half) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = bits[i];
            repeat (half) @(negedge clk);
            sclk = 1'b1;
            repeat (half) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (half) @(negedge clk);
        if (chk_busy) check("busy_in_frame", busy, 1);
        cs = 1'b1;
        if (chk_busy) begin
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (busy && n < 20);
            check("busy_drop_clks", n, SYNC + 1);
        end
        repeat (gap) @(negedge clk);
    endtask

    task automatic dbg_check(input int a, input string name);
        @(negedge clk);
        dbg_addr = ADDR_W'(a);
        @(posedge clk);
        @(posedge clk);
        #1;
        check(name, dbg_data, model[a]);
    endtask

    task automatic do_write(input int a, input logic [7:0] d, input int half, input int gap);
        logic [7:0] c;
        c = 8'h80 | 8'(a);
        exp_wr.push_back(1);
        model[a] = d;
        spi_frame({8'h00, c, d}, 16, half, gap, 1'b0);
    endtask

    task automatic do_read(input int a, input int half, input int gap);
        logic [7:0] c;
        c = 8'(a);
        exp_rd.push_back(model[a]);
        spi_frame({8'h00, c, 8'h00}, 16, half, gap, 1'b0);
    endtask

    initial begin : stim
        logic [15:0] f;
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("rst_miso", miso, 0);
        check("rst_busy", busy, 0);
        check("rst_wr", wr_pulse, 0);
        check("rst_rd", rd_pulse, 0);
        check("rst_dbg", dbg_data, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        dbg_check(9, "rst_mem9");

        // Write 0x83/0xA5 with busy timing.
        exp_wr.push_back(1);
        model[3] = 8'hA5;
        spi_frame(24'h0083A5, 16, 10, 10, 1'b1);
        dbg_check(3, "wr_a5");

        // Read it back serially.
        do_read(3, 10, 10);

        // Aborted write after 12 bits, then the full one.
        f = 16'h873C;
        spi_frame({12'h000, f[15:4]}, 12, 10, 10, 1'b0);
        check("abort_idle", busy, 0);
        dbg_check(7, "abort_mem7");
        do_write(7, 8'h3C, 10, 10);
        dbg_check(7, "wr_3c");

        // 24-bit frame: trailing byte must be ignored.
        exp_wr.push_back(1);
        model[1] = 8'hFF;
        spi_frame(24'h81FF00, 24, 8, 10, 1'b0);
        dbg_check(1, "wr24_mem1");

        // Reset after 10 bits of a write to address 5.
        do_write(5, 8'h77, 8, 10);
        @(negedge clk);
        dbg_addr = ADDR_W'(5);
        cs = 1'b0;
        f = 16'h8512;
        repeat (8) @(negedge clk);
        for (int i = 15; i >= 6; i--) begin
            mosi = f[i];
            repeat (8) @(negedge clk);
            sclk = 1'b1;
            repeat (8) @(negedge clk);
            sclk = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_miso", miso, 0);
        check("midrst_busy", busy, 0);
        check("midrst_wr", wr_pulse, 0);
        check("midrst_rd", rd_pulse, 0);
        check("midrst_dbg", dbg_data, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
        // cs stays low: these edges must not start a frame.
        for (int i = 0; i < 22; i++) begin
            mosi = 1'b1;
            repeat (8) @(negedge clk);
            sclk = 1'b1;
            repeat (8) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (8) @(negedge clk);
        cs = 1'b1;
        repeat (10) @(negedge clk);
        dbg_check(5, "midrst_mem5");
        dbg_check(3, "midrst_mem3");

        // Back-to-back frames, 4 clk of cs high between.
        do_write(15, 8'h5A, 8, 4);
        do_read(15, 8, 10);

        // Random traffic against the array model.
        for (int k = 0; k < 40; k++) begin
            int a, half, kind;
            logic [7:0] d;
            a    = int'($urandom_range(DEPTH - 1, 0));
            half = int'($urandom_range(12, 6));
            kind = int'($urandom_range(9, 0));
            d    = 8'($urandom);
            if (kind == 0) begin
                int nb;
                nb = int'($urandom_range(15, 1));
                f  = {8'h80 | 8'(a), d};
                spi_frame(24'(f >> (16 - nb)), nb, half, 6, 1'b0);
            end else if (kind < 5) begin
                do_write(a, d, half, int'($urandom_range(10, 4)));
            end else begin
                do_read(a, half, int'($urandom_range(10, 4)));
            end
        end

        for (int i = 0; i < DEPTH; i++) dbg_check(i, "final_mem");
        repeat (20) @(negedge clk);
        check("pending_wr", exp_wr.size(), 0);
        check("pending_rd", exp_rd.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
